// File: rtl/op_scheduler.sv
// Delayed-op scheduler: queues {delay, op} commands, arms an external down-counter per entry, and strobes the op when it expires.
// Optional build macro SCHED_TIMESTAMP_EN adds time_in/op_time to stamp each issued op.
module op_scheduler #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_wr,
  input  logic [47:0]              cmd_delay,
  input  logic [15:0]              cmd_op,
  output logic                     cmd_full,
  output logic [$clog2(DEPTH):0]   cmd_count,
  input  logic                     run,
  input  logic                     abort,
  output logic                     busy,
  output logic [47:0]              timer_data,
  output logic                     timer_start,
  input  logic                     timer_rdy,
  output logic                     op_strobe,
  output logic [15:0]              op_code,
  output logic                     done,
  output logic                     err_ovf,
`ifdef SCHED_TIMESTAMP_EN
  input  logic [47:0]              time_in,
  output logic [47:0]              op_time,
`endif
  output logic [2:0]               o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP       = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_FIRE      = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [63:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic [47:0]     r_delay;
  logic [15:0]     r_op;
  logic [15:0]     r_op_code;
  logic            r_err;
  logic [63:0]     w_head;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_fire;
  logic            w_have;

  // Handshakes: a command is accepted on any cycle with cmd_wr=1 and cmd_full=0
  // (no back-pressure beyond cmd_full); the timer is armed by a one-cycle
  // timer_start and reports completion by timer_rdy falling then rising.
  assign w_head = r_mem[r_rptr];
  assign w_full = (r_count == CNT_FULL);
  assign w_have = (r_count != '0);
  assign w_push = cmd_wr && !w_full && !abort;
  assign w_pop  = (r_state == S_POP) && !abort;
  assign w_fire = (r_state == S_FIRE) && !abort;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (run && w_have && timer_rdy) w_next = S_POP;
      S_POP:       w_next = (w_head[63:16] == '0) ? S_FIRE : S_START;
      S_START:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!timer_rdy) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (timer_rdy) w_next = S_FIRE;
      S_FIRE:      w_next = (run && w_have) ? S_POP : S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {cmd_delay, cmd_op};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_delay   <= '0;
      r_op      <= '0;
      r_op_code <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (cmd_wr && w_full) r_err <= 1'b1;
      if (abort) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_ONE;
        if (w_pop) begin
          r_rptr  <= r_rptr + PTR_ONE;
          r_delay <= w_head[63:16];
          r_op    <= w_head[15:0];
        end
        if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
        else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
      end
      if (w_fire) r_op_code <= r_op;
    end
  end

`ifdef SCHED_TIMESTAMP_EN
  logic [47:0] r_op_time;
  always_ff @(posedge clk) begin
    if (rst)         r_op_time <= '0;
    else if (w_fire) r_op_time <= time_in;
  end
  assign op_time = w_fire ? time_in : r_op_time;
`endif

  // op_code/op_time switch to the new value combinationally in the FIRE cycle.
  assign cmd_full    = w_full;
  assign cmd_count   = r_count;
  assign busy        = (r_state != S_IDLE);
  assign timer_data  = r_delay;
  assign timer_start = (r_state == S_START);
  assign op_strobe   = w_fire;
  assign op_code     = w_fire ? r_op : r_op_code;
  assign done        = w_fire && !w_have;
  assign err_ovf     = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_op_scheduler.sv
// Directed bench for op_scheduler: one task per scenario with inline checks.
module tb_op_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [47:0] cmd_delay = '0;
  logic [15:0] cmd_op = '0;
  logic        cmd_full;
  logic [3:0]  cmd_count;
  logic        run = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic [47:0] timer_data;
  logic        timer_start;
  logic        timer_rdy = 1'b1;
  logic        op_strobe;
  logic [15:0] op_code;
  logic        done;
  logic        err_ovf;
  logic [2:0]  dbg_state;
`ifdef SCHED_TIMESTAMP_EN
  logic [47:0] time_in = '0;
  logic [47:0] op_time;
`endif

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  int n_start = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_op;

  op_scheduler #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .cmd_delay(cmd_delay), .cmd_op(cmd_op),
    .cmd_full(cmd_full), .cmd_count(cmd_count), .run(run), .abort(abort), .busy(busy),
    .timer_data(timer_data), .timer_start(timer_start), .timer_rdy(timer_rdy),
    .op_strobe(op_strobe), .op_code(op_code), .done(done), .err_ovf(err_ovf),
`ifdef SCHED_TIMESTAMP_EN
    .time_in(time_in), .op_time(op_time),
`endif
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (op_strobe === 1'b1) n_strobe++;
    if (timer_start === 1'b1) n_start++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [47:0] d, input logic [15:0] op);
    cmd_wr = 1'b1; cmd_delay = d; cmd_op = op;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (cmd_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", cmd_count); end
    checks++; if (cmd_full !== 1'b0) begin errors++; $display("FAIL rst_full got %0b exp 0", cmd_full); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (timer_start !== 1'b0 || timer_data !== 48'd0) begin errors++; $display("FAIL rst_timer got %0b/%0h exp 0/0", timer_start, timer_data); end
    checks++; if (op_strobe !== 1'b0 || op_code !== 16'h0) begin errors++; $display("FAIL rst_op got %0b/%h exp 0/0000", op_strobe, op_code); end
    checks++; if (done !== 1'b0 || err_ovf !== 1'b0) begin errors++; $display("FAIL rst_flags got %0b/%0b exp 0/0", done, err_ovf); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_zero_delay();
    push(48'd0, 16'h0011);
    checks++; if (cmd_count !== 4'd1) begin errors++; $display("FAIL zd_count got %0d exp 1", cmd_count); end
    run = 1'b1;
    tick();
    checks++; if (busy !== 1'b1 || op_strobe !== 1'b0) begin errors++; $display("FAIL zd_pop got busy %0b strobe %0b exp 1/0", busy, op_strobe); end
    tick();
    checks++; if (op_strobe !== 1'b1 || op_code !== 16'h0011 || done !== 1'b1) begin errors++; $display("FAIL zd_fire got %0b/%h/%0b exp 1/0011/1", op_strobe, op_code, done); end
    run = 1'b0;
    tick();
    checks++; if (op_strobe !== 1'b0 || busy !== 1'b0 || op_code !== 16'h0011) begin errors++; $display("FAIL zd_after got %0b/%0b/%h exp 0/0/0011", op_strobe, busy, op_code); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      push(48'd0, 16'h0101 * (i + 1));
      exp_q.push_back(16'h0101 * (i + 1));
    end
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (op_strobe !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d got %0b exp 0", i, op_strobe); end
      tick();
      exp_op = exp_q.pop_front();
      checks++; if (op_strobe !== 1'b1 || op_code !== exp_op || done !== (i == 2)) begin
        errors++; $display("FAIL b2b_fire%0d got %0b/%h/%0b exp 1/%h/%0b", i, op_strobe, op_code, done, exp_op, i == 2); end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_timer();
    int s0;
    s0 = n_start;
    push(48'd100, 16'h00A5);
    run = 1'b1;
    tick();
    tick();
    checks++; if (timer_start !== 1'b1 || timer_data !== 48'd100) begin errors++; $display("FAIL tmr_start got %0b/%0d exp 1/100", timer_start, timer_data); end
    tick();
    timer_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (op_strobe !== 1'b0 || timer_start !== 1'b0 || timer_data !== 48'd100) begin
        errors++; $display("FAIL tmr_wait%0d got %0b/%0b/%0d exp 0/0/100", i, op_strobe, timer_start, timer_data); end
    end
    timer_rdy = 1'b1;
    tick();
    checks++; if (op_strobe !== 1'b1 || op_code !== 16'h00A5 || done !== 1'b1) begin errors++; $display("FAIL tmr_fire got %0b/%h/%0b exp 1/00a5/1", op_strobe, op_code, done); end
    run = 1'b0;
    tick();
    checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL tmr_nstart got %0d exp 1", n_start - s0); end
  endtask

  task automatic test_overflow();
    int s0;
    for (int i = 0; i < 8; i++) begin
      push(48'd0, 16'h0100 + 16'(i));
      exp_q.push_back(16'h0100 + 16'(i));
    end
    checks++; if (cmd_full !== 1'b1 || cmd_count !== 4'd8 || err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_full got %0b/%0d/%0b exp 1/8/0", cmd_full, cmd_count, err_ovf); end
    push(48'd0, 16'hDEAD);
    checks++; if (cmd_full !== 1'b1 || cmd_count !== 4'd8 || err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_drop got %0b/%0d/%0b exp 1/8/1", cmd_full, cmd_count, err_ovf); end
    s0 = n_strobe;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      tick();
      exp_op = exp_q.pop_front();
      checks++; if (op_strobe !== 1'b1 || op_code !== exp_op) begin errors++; $display("FAIL ovf_fire%0d got %0b/%h exp 1/%h", i, op_strobe, op_code, exp_op); end
    end
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0 || cmd_count !== 4'd0 || op_code !== 16'h0107) begin errors++; $display("FAIL ovf_idle got %0b/%0d/%h exp 0/0/0107", busy, cmd_count, op_code); end
    checks++; if (n_strobe - s0 !== 8 || err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_nstrobe got %0d/%0b exp 8/1", n_strobe - s0, err_ovf); end
    run = 1'b0;
  endtask

  task automatic test_abort();
    int s0;
    push(48'd50, 16'h0AAA);
    for (int i = 1; i <= 3; i++) push(48'd0, 16'h0B00 + 16'(i));
    s0 = n_strobe;
    run = 1'b1;
    tick(); tick(); tick();
    timer_rdy = 1'b0;
    tick();
    checks++; if (dbg_state !== 3'd4 || cmd_count !== 4'd3) begin errors++; $display("FAIL abt_pre got %0d/%0d exp 4/3", dbg_state, cmd_count); end
    abort = 1'b1; cmd_wr = 1'b1; cmd_delay = 48'd0; cmd_op = 16'h0BAD;
    tick();
    abort = 1'b0; cmd_wr = 1'b0;
    checks++; if (busy !== 1'b0 || cmd_count !== 4'd0 || dbg_state !== 3'd0) begin errors++; $display("FAIL abt_idle got %0b/%0d/%0d exp 0/0/0", busy, cmd_count, dbg_state); end
    push(48'd0, 16'h0C0C);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (busy !== 1'b0 || cmd_count !== 4'd1) begin errors++; $display("FAIL abt_hold%0d got %0b/%0d exp 0/1", i, busy, cmd_count); end
    end
    checks++; if (n_strobe - s0 !== 0) begin errors++; $display("FAIL abt_nostrobe got %0d exp 0", n_strobe - s0); end
    timer_rdy = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abt_resume got %0b exp 1", busy); end
    tick();
    checks++; if (op_strobe !== 1'b1 || op_code !== 16'h0C0C || done !== 1'b1) begin errors++; $display("FAIL abt_fire got %0b/%h/%0b exp 1/0c0c/1", op_strobe, op_code, done); end
    run = 1'b0;
    tick();
  endtask

  task automatic test_run_fall();
    push(48'd0, 16'h0D01);
    push(48'd0, 16'h0D02);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    checks++; if (op_strobe !== 1'b1 || op_code !== 16'h0D01 || done !== 1'b0) begin errors++; $display("FAIL rf_fire got %0b/%h/%0b exp 1/0d01/0", op_strobe, op_code, done); end
    tick(); tick();
    checks++; if (busy !== 1'b0 || cmd_count !== 4'd1 || op_code !== 16'h0D01) begin errors++; $display("FAIL rf_stop got %0b/%0d/%h exp 0/1/0d01", busy, cmd_count, op_code); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (cmd_count !== 4'd0) begin errors++; $display("FAIL rf_flush got %0d exp 0", cmd_count); end
  endtask

`ifdef SCHED_TIMESTAMP_EN
  task automatic test_timestamp();
    push(48'd0, 16'h0E0E);
    run = 1'b1;
    tick();
    time_in = 48'h0000_1234_5678;
    tick();
    checks++; if (op_strobe !== 1'b1 || op_time !== 48'h0000_1234_5678) begin errors++; $display("FAIL ts_fire got %0b/%h exp 1/000012345678", op_strobe, op_time); end
    run = 1'b0;
    time_in = 48'h0000_0000_0099;
    tick();
    checks++; if (op_time !== 48'h0000_1234_5678) begin errors++; $display("FAIL ts_hold got %h exp 000012345678", op_time); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_delay();
    test_back_to_back();
    test_timer();
    test_overflow();
    test_abort();
    test_run_fall();
`ifdef SCHED_TIMESTAMP_EN
    test_timestamp();
`endif
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/op_scheduler.md
OP_SCHEDULER -- requirements
Module: op_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, command queue depth (power of 2, 2..64).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port: cmd_wr  input  1  push {cmd_delay, cmd_op} into queue.
REQ-006 SHALL have port: cmd_delay  input  48  delay in clk cycles before the op fires.
REQ-007 SHALL have port: cmd_op  input  16  op code issued when the delay expires.
REQ-008 SHALL have port: cmd_full  output  1  queue holds DEPTH entries.
REQ-009 SHALL have port: cmd_count  output  log2(DEPTH)+1  current queue occupancy.
REQ-010 SHALL have port: run  input  1  level; permits popping new entries.
REQ-011 SHALL have port: abort  input  1  pulse; flush queue, return to IDLE.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port: timer_data  output  48  load value for the external down-counter delay timer.
REQ-014 SHALL have port: timer_start  output  1  one-cycle start pulse to the timer.
REQ-015 SHALL have port: timer_rdy  input  1  timer idle (low while counting).
REQ-016 SHALL have port: op_strobe  output  1  one-cycle pulse; op issued.
REQ-017 SHALL have port: op_code  output  16  code of the issued op, held until the next strobe.
REQ-018 SHALL have port: done  output  1  one-cycle pulse when the queue drains after an op.
REQ-019 SHALL have port: err_ovf  output  1  sticky; cmd_wr seen while cmd_full.

Function
REQ-020 SHALL push on cmd_wr && !cmd_full; cmd_wr while full is dropped and sets err_ovf.
REQ-021 SHALL leave cmd_count unchanged on a simultaneous push and pop.
REQ-022 SHALL implement FSM states IDLE, POP, START, WAIT_BUSY, WAIT_DONE, FIRE.
REQ-023 SHALL transition IDLE->POP when run && cmd_count>0 && timer_rdy; POP latches the head entry and advances the read pointer.
REQ-024 SHALL transition POP->FIRE if the latched delay==0, else POP->START.
REQ-025 SHALL assert timer_start in START only, then go to WAIT_BUSY; timer_data SHALL hold the latched delay from POP until FIRE.
REQ-026 SHALL transition WAIT_BUSY->WAIT_DONE when timer_rdy==0, and WAIT_DONE->FIRE when timer_rdy==1.
REQ-027 SHALL assert op_strobe in FIRE only and update op_code to the latched op in that cycle.
REQ-028 SHALL go from FIRE to POP if run && cmd_count>0, else to IDLE; done SHALL pulse in FIRE when cmd_count==0.
REQ-029 SHALL produce op_strobe 2 cycles after run is sampled high for a zero-delay head; back-to-back zero-delay ops SHALL issue every 2 cycles.
REQ-030 SHALL, when run falls mid-operation, complete the current entry and then stop in IDLE.
REQ-031 SHALL, on abort in any state, enter IDLE next cycle, empty the queue, and suppress op_strobe and done; abort has priority over cmd_wr in the same cycle.
REQ-032 SHALL not leave IDLE after an abort until timer_rdy==1 (enforced by REQ-023).

Reset
REQ-033 SHALL, on rst, set state IDLE, empty the queue, and set cmd_count=0, cmd_full=0, busy=0, timer_start=0, timer_data=0, op_strobe=0, op_code=0, done=0, err_ovf=0.
REQ-034 SHALL give rst priority over abort, run and cmd_wr; rst mid-operation discards the active entry.

Configuration
REQ-035 SHALL, with SCHED_TIMESTAMP_EN defined, add ports time_in (input, 48, free-running clock count) and op_time (output, 48); op_time captures time_in in the FIRE cycle and resets to 0.
REQ-036 SHALL, without SCHED_TIMESTAMP_EN, omit time_in and op_time; all other behaviour is unchanged.

Verification
REQ-037 SHALL check: push (delay 0, op 0x0011), run=1 -> op_strobe 2 cycles later, op_code=0x0011, done in the same cycle.
REQ-038 SHALL check: push (delay 100, op 0x00A5) with a timer model that drops rdy 1 cycle after start -> one timer_start, timer_data=100, op_strobe 1 cycle after rdy returns.
REQ-039 SHALL check: DEPTH=8, 9 pushes with run=0 -> cmd_full=1, cmd_count=8, err_ovf=1, the 9th op never issued.
REQ-040 SHALL check: abort during WAIT_DONE with 3 entries queued -> IDLE, cmd_count=0, no op_strobe, and no pop until timer_rdy=1.
REQ-041 SHALL check: with SCHED_TIMESTAMP_EN, time_in=0x0000_1234_5678 in the FIRE cycle -> op_time=0x0000_1234_5678.
